// File: rtl/rc5_decrypt_core.sv
// Iterative RC5-16 decryption core: one full round per clock, software-loaded key table.
// Optional macro RC5_DEC_KEY_LOCK_EN: when defined, key writes are dropped outside IDLE.
//   state | meaning
//   IDLE  | waiting for ciphertext, ct_ready_o high
//   ROUND | one inverse round per cycle, counter runs ROUNDS..1
//   FINAL | remove the S[0]/S[1] whitening
//   DONE  | plaintext held until pt_ready_i
module rc5_decrypt_core #(
    parameter int ROUNDS = 12,
    parameter int KA_W   = $clog2(2*ROUNDS+2)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            key_we_i,
    input  logic [KA_W-1:0] key_addr_i,
    input  logic [15:0]     key_data_i,
    input  logic            ct_valid_i,
    output logic            ct_ready_o,
    input  logic [31:0]     ct_i,
    output logic            pt_valid_o,
    input  logic            pt_ready_i,
    output logic [31:0]     pt_o,
    output logic            busy_o
);

    localparam int NWORDS = 2*ROUNDS+2;
    localparam logic [KA_W:0] NWORDS_C = (KA_W+1)'(NWORDS);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t          state;
    logic [15:0]     a, b;
    logic [7:0]      rnd;
    logic [15:0]     s_tab [NWORDS];
    logic [KA_W-1:0] idx_a, idx_b;
    logic [15:0]     a_n, b_n;
    logic            key_wr_ok;

    // Rotating the doubled word keeps amount 0 an identity without a 16-bit shift.
    function automatic logic [15:0] rotr16(input logic [15:0] x, input logic [3:0] n);
        return 16'({x, x} >> n);
    endfunction

    always_comb begin
        idx_a = KA_W'({rnd, 1'b0});
        idx_b = KA_W'({rnd, 1'b1});
        b_n   = rotr16(b - s_tab[idx_b], a[3:0]) ^ a;
        a_n   = rotr16(a - s_tab[idx_a], b_n[3:0]) ^ b_n;
    end

`ifdef RC5_DEC_KEY_LOCK_EN
    assign key_wr_ok = key_we_i && ({1'b0, key_addr_i} < NWORDS_C) && (state == IDLE);
`else
    assign key_wr_ok = key_we_i && ({1'b0, key_addr_i} < NWORDS_C);
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int n = 0; n < NWORDS; n++) s_tab[n] <= '0;
        end else if (key_wr_ok) begin
            s_tab[key_addr_i] <= key_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            a          <= '0;
            b          <= '0;
            rnd        <= '0;
            ct_ready_o <= 1'b1;
            pt_valid_o <= 1'b0;
            busy_o     <= 1'b0;
            pt_o       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ct_valid_i && ct_ready_o) begin
                        a          <= ct_i[15:0];
                        b          <= ct_i[31:16];
                        rnd        <= 8'(ROUNDS);
                        ct_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                        state      <= ROUND;
                    end
                end
                ROUND: begin
                    a <= a_n;
                    b <= b_n;
                    if (rnd == 8'd1) state <= FINAL;
                    else             rnd   <= rnd - 8'd1;
                end
                FINAL: begin
                    b          <= b - s_tab[1];
                    a          <= a - s_tab[0];
                    pt_o       <= {b - s_tab[1], a - s_tab[0]};
                    pt_valid_o <= 1'b1;
                    busy_o     <= 1'b0;
                    state      <= DONE;
                end
                DONE: begin
                    // Ready returns together with IDLE, so it is seen the cycle after the handshake.
                    if (pt_ready_i) begin
                        pt_valid_o <= 1'b0;
                        ct_ready_o <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_decrypt_core.sv
// Directed bench for rc5_decrypt_core: a ROUNDS=1 instance for hand vectors and a
// ROUNDS=12 instance checked against an RC5 encrypt model.
module tb_rc5_decrypt_core;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        k1_we;
    logic [1:0]  k1_addr;
    logic [15:0] k1_data;
    logic        v1, rdy1, pv1, pr1, busy1;
    logic [31:0] ct1, pt1;

    logic        k12_we;
    logic [4:0]  k12_addr;
    logic [15:0] k12_data;
    logic        v12, rdy12, pv12, pr12, busy12;
    logic [31:0] ct12, pt12;

    logic [15:0] kt [26];

    rc5_decrypt_core #(.ROUNDS(1)) u_r1 (
        .clk_i(clk), .rst_n_i(rst_n),
        .key_we_i(k1_we), .key_addr_i(k1_addr), .key_data_i(k1_data),
        .ct_valid_i(v1), .ct_ready_o(rdy1), .ct_i(ct1),
        .pt_valid_o(pv1), .pt_ready_i(pr1), .pt_o(pt1), .busy_o(busy1)
    );

    rc5_decrypt_core #(.ROUNDS(12)) u_r12 (
        .clk_i(clk), .rst_n_i(rst_n),
        .key_we_i(k12_we), .key_addr_i(k12_addr), .key_data_i(k12_data),
        .ct_valid_i(v12), .ct_ready_o(rdy12), .ct_i(ct12),
        .pt_valid_o(pv12), .pt_ready_i(pr12), .pt_o(pt12), .busy_o(busy12)
    );

    function automatic logic [15:0] rotl16(input logic [15:0] x, input logic [3:0] n);
        if (n == 4'd0) return x;
        return (x << n) | (x >> (16 - int'(n)));
    endfunction

    function automatic logic [31:0] enc12(input logic [31:0] p);
        logic [15:0] a, b;
        a = p[15:0]  + kt[0];
        b = p[31:16] + kt[1];
        for (int i = 1; i <= 12; i++) begin
            a = rotl16(a ^ b, b[3:0]) + kt[2*i];
            b = rotl16(b ^ a, a[3:0]) + kt[2*i+1];
        end
        return {b, a};
    endfunction

    task automatic load1(input logic [15:0] val);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            k1_we = 1'b1; k1_addr = 2'(n); k1_data = val;
        end
        @(negedge clk);
        k1_we = 1'b0;
    endtask

    task automatic load12();
        for (int n = 0; n < 26; n++) begin
            @(negedge clk);
            k12_we = 1'b1; k12_addr = 5'(n); k12_data = kt[n];
        end
        @(negedge clk);
        k12_we = 1'b0;
    endtask

    task automatic xfer1(input logic [31:0] ct, output logic [31:0] pt, output int lat);
        @(negedge clk);
        ct1 = ct; v1 = 1'b1; pr1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        lat = 0;
        while (!pv1 && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        pt = pt1;
        @(posedge clk);
        @(negedge clk);
        pr1 = 1'b0;
    endtask

    task automatic xfer12(input logic [31:0] ct, input int hold, output logic [31:0] pt,
                          output int lat, output bit rdy_bad, output bit unstable, output bit post_ok);
        rdy_bad = 1'b0; unstable = 1'b0;
        @(negedge clk);
        ct12 = ct; v12 = 1'b1; pr12 = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        v12 = 1'b0;
        if (rdy12 !== 1'b0 || busy12 !== 1'b1) rdy_bad = 1'b1;
        lat = 0;
        while (!pv12 && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
            if (rdy12 !== 1'b0) rdy_bad = 1'b1;
        end
        pt = pt12;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk);
            if (pt12 !== pt || pv12 !== 1'b1 || rdy12 !== 1'b0) unstable = 1'b1;
        end
        pr12 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        post_ok = (rdy12 === 1'b1) && (pv12 === 1'b0) && (busy12 === 1'b0);
        pr12 = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (rdy12 !== 1'b1) begin bad++; $display("FAIL reset_ct_ready got %b want 1", rdy12); end
        total++; if (pv12 !== 1'b0) begin bad++; $display("FAIL reset_pt_valid got %b want 0", pv12); end
        total++; if (busy12 !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy12); end
        total++; if (pt12 !== 32'h0) begin bad++; $display("FAIL reset_pt got %h want 00000000", pt12); end
        total++; if (rdy1 !== 1'b1 || pv1 !== 1'b0) begin bad++; $display("FAIL reset_r1 got rdy=%b pv=%b want 1 0", rdy1, pv1); end
    endtask

    task automatic test_r1_vectors();
        logic [31:0] pt;
        int lat;
        load1(16'h0000);
        xfer1(32'h0002_0001, pt, lat);
        total++; if (pt !== 32'h0000_0001) begin bad++; $display("FAIL r1_rot0 got %h want 00000001", pt); end
        total++; if (lat != 2) begin bad++; $display("FAIL r1_latency got %0d want 2", lat); end
        load1(16'h0001);
        xfer1(32'h0000_0000, pt, lat);
        total++; if (pt !== 32'hFFFE_FFFF) begin bad++; $display("FAIL r1_wrap got %h want fffeffff", pt); end
        total++; if (lat != 2) begin bad++; $display("FAIL r1_wrap_latency got %0d want 2", lat); end
    endtask

    task automatic test_roundtrip();
        logic [31:0] pv [3] = '{32'h1234_5678, 32'hFFFF_0000, 32'h0F0F_A5A5};
        logic [31:0] pt;
        int lat;
        bit rb, us, po;
        for (int n = 0; n < 26; n++) kt[n] = 16'($urandom);
        load12();
        for (int t = 0; t < 3; t++) begin
            xfer12(enc12(pv[t]), 0, pt, lat, rb, us, po);
            total++; if (pt !== pv[t]) begin bad++; $display("FAIL roundtrip_%0d got %h want %h", t, pt, pv[t]); end
            total++; if (lat != 13) begin bad++; $display("FAIL latency_%0d got %0d want 13", t, lat); end
            total++; if (rb) begin bad++; $display("FAIL ready_low_%0d got ready/busy glitch want ready=0 busy=1", t); end
            total++; if (!po) begin bad++; $display("FAIL post_handshake_%0d got rdy=%b pv=%b want rdy=1 pv=0", t, rdy12, pv12); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pt;
        int lat;
        bit rb, us, po;
        xfer12(enc12(32'hCAFE_BEEF), 10, pt, lat, rb, us, po);
        total++; if (pt !== 32'hCAFE_BEEF) begin bad++; $display("FAIL bp_result got %h want cafebeef", pt); end
        total++; if (us) begin bad++; $display("FAIL bp_hold got unstable output want stable pt with ready=0"); end
        total++; if (!po) begin bad++; $display("FAIL bp_release got rdy=%b pv=%b want rdy=1 pv=0", rdy12, pv12); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pin [2] = '{32'h0001_0002, 32'h8000_7FFF};
        logic [31:0] cin [2];
        logic [31:0] got [2];
        int tacc [2];
        int cyc = 0, nacc = 0, nout = 0;
        cin[0] = enc12(pin[0]);
        cin[1] = enc12(pin[1]);
        got[0] = '0; got[1] = '0; tacc[0] = 0; tacc[1] = 0;
        pr12 = 1'b1;
        while (nout < 2 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (nacc < 2) begin ct12 = cin[nacc]; v12 = 1'b1; end
            else v12 = 1'b0;
            if (v12 && rdy12) begin tacc[nacc] = cyc; nacc++; end
            if (pv12) begin got[nout] = pt12; nout++; end
            @(posedge clk);
        end
        @(negedge clk);
        v12 = 1'b0; pr12 = 1'b0;
        total++; if (nout != 2) begin bad++; $display("FAIL b2b_count got %0d want 2", nout); end
        total++; if (tacc[1] - tacc[0] != 15) begin bad++; $display("FAIL b2b_period got %0d want 15", tacc[1] - tacc[0]); end
        total++; if (got[0] !== pin[0]) begin bad++; $display("FAIL b2b_first got %h want %h", got[0], pin[0]); end
        total++; if (got[1] !== pin[1]) begin bad++; $display("FAIL b2b_second got %h want %h", got[1], pin[1]); end
    endtask

    task automatic test_oob_write();
        logic [31:0] pt;
        int lat;
        bit rb, us, po;
        for (int n = 26; n < 32; n++) begin
            @(negedge clk);
            k12_we = 1'b1; k12_addr = 5'(n); k12_data = 16'h1234;
        end
        @(negedge clk);
        k12_we = 1'b0;
        xfer12(enc12(32'h5A5A_C3C3), 0, pt, lat, rb, us, po);
        total++; if (pt !== 32'h5A5A_C3C3) begin bad++; $display("FAIL oob_write got %h want 5a5ac3c3", pt); end
    endtask

`ifdef RC5_DEC_KEY_LOCK_EN
    task automatic test_key_lock();
        logic [31:0] pt;
        int lat;
        bit rb, us, po;
        @(negedge clk);
        ct12 = enc12(32'h2468_ACE0); v12 = 1'b1; pr12 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        v12 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        k12_we = 1'b1; k12_addr = 5'd2; k12_data = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        k12_we = 1'b0;
        lat = 0;
        while (!pv12 && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        total++; if (pt12 !== 32'h2468_ACE0) begin bad++; $display("FAIL lock_inflight got %h want 2468ace0", pt12); end
        pr12 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pr12 = 1'b0;
        xfer12(enc12(32'h1357_9BDF), 0, pt, lat, rb, us, po);
        total++; if (pt !== 32'h1357_9BDF) begin bad++; $display("FAIL lock_table got %h want 13579bdf", pt); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] pt;
        logic [15:0] saved [26];
        int lat;
        bit rb, us, po;
        @(negedge clk);
        ct12 = enc12(32'h7777_1111); v12 = 1'b1; pr12 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        v12 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++; if (busy12 !== 1'b1) begin bad++; $display("FAIL mid_busy got %b want 1", busy12); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (rdy12 !== 1'b1) begin bad++; $display("FAIL rst_ct_ready got %b want 1", rdy12); end
        total++; if (pv12 !== 1'b0) begin bad++; $display("FAIL rst_pt_valid got %b want 0", pv12); end
        total++; if (busy12 !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy12); end
        total++; if (pt12 !== 32'h0) begin bad++; $display("FAIL rst_pt got %h want 00000000", pt12); end
        @(negedge clk);
        rst_n = 1'b1;
        saved = kt;
        for (int n = 0; n < 26; n++) kt[n] = 16'h0000;
        xfer12(enc12(32'h9ABC_DEF0), 0, pt, lat, rb, us, po);
        total++; if (pt !== 32'h9ABC_DEF0) begin bad++; $display("FAIL rst_zero_keys got %h want 9abcdef0", pt); end
        kt = saved;
        load12();
        xfer12(enc12(32'h7777_1111), 0, pt, lat, rb, us, po);
        total++; if (pt !== 32'h7777_1111) begin bad++; $display("FAIL rst_reload got %h want 77771111", pt); end
        total++; if (lat != 13) begin bad++; $display("FAIL rst_reload_latency got %0d want 13", lat); end
    endtask

    initial begin
        rst_n = 1'b0;
        k1_we = 1'b0; k1_addr = '0; k1_data = '0; v1 = 1'b0; pr1 = 1'b0; ct1 = '0;
        k12_we = 1'b0; k12_addr = '0; k12_data = '0; v12 = 1'b0; pr12 = 1'b0; ct12 = '0;
        for (int n = 0; n < 26; n++) kt[n] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_r1_vectors();
        test_roundtrip();
        test_backpressure();
        test_back_to_back();
        test_oob_write();
`ifdef RC5_DEC_KEY_LOCK_EN
        test_key_lock();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
